// File: rtl/udp_word_packer_pkg.sv
// Shared types and constants for the UDP payload word packer.
package udp_word_packer_pkg;

    localparam int unsigned OUT_BYTES_C = 4;
    localparam int unsigned KEEP_W      = OUT_BYTES_C;
    localparam int unsigned WORD_W      = 8 * OUT_BYTES_C;
    localparam int unsigned IDX_W       = 3;

    // Packer FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PACK = 2'd1;
    localparam state_t ST_EMIT = 2'd2;

    // Keep mask after placing byte at index i (entry i), MSB-contiguous
    localparam logic [OUT_BYTES_C*KEEP_W-1:0] KEEP_TBL = {4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Look up the keep mask for a byte index; out-of-range indices mean a full word
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [IDX_W-1:0] idx);
        int unsigned i;
        i = 32'(idx);
        if (i >= OUT_BYTES_C) begin
            return '1;
        end
        return KEEP_TBL[i*KEEP_W +: KEEP_W];
    endfunction

endpackage

// File: rtl/udp_word_packer_if.sv
// Byte-FIFO read side and word-FIFO write side seen by the packer.
interface udp_word_packer_if;

    logic [7:0]                                    in_dout;
    logic                                          in_sof;
    logic                                          in_eof;
    logic                                          in_empty;
    logic                                          in_rd_en;

    logic [udp_word_packer_pkg::WORD_W-1:0]        out_dout;
    logic [udp_word_packer_pkg::KEEP_W-1:0]        out_keep;
    logic                                          out_sof;
    logic                                          out_eof;
    logic                                          out_wr_en;
    logic                                          out_full;

    // Packer side: pops bytes, pushes words
    modport master (
        input  in_dout, in_sof, in_eof, in_empty,
        output in_rd_en,
        output out_dout, out_keep, out_sof, out_eof, out_wr_en,
        input  out_full
    );

    // FIFO side: supplies bytes, accepts words
    modport slave (
        output in_dout, in_sof, in_eof, in_empty,
        input  in_rd_en,
        input  out_dout, out_keep, out_sof, out_eof, out_wr_en,
        output out_full
    );

endinterface

// File: rtl/udp_word_packer.sv
// Packs UDP payload bytes big-endian into keep-masked words and keeps packet statistics.
module udp_word_packer
    import udp_word_packer_pkg::*;
#(
    parameter int unsigned OUT_BYTES = OUT_BYTES_C,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    udp_word_packer_if.master     bus,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  last_len
);

    localparam int unsigned WW = 8 * OUT_BYTES;

    state_t                state_q,    state_d;
    logic [WW-1:0]         word_q,     word_d;
    logic [KEEP_W-1:0]     keep_q,     keep_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [CNT_WIDTH-1:0]  len_q,      len_d;
    logic [CNT_WIDTH-1:0]  pkt_q,      pkt_d;
    logic [CNT_WIDTH-1:0]  err_q,      err_d;
    logic [CNT_WIDTH-1:0]  last_len_q, last_len_d;
    logic                  first_q,    first_d;
    logic                  eof_q,      eof_d;
    logic                  trunc_q,    trunc_d;
    logic                  orphan_q,   orphan_d;
    logic                  rd_en_c;
    logic                  wr_en_c;

    // Next-state, datapath and strobe decode
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        keep_d     = keep_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pkt_d      = pkt_q;
        err_d      = err_q;
        last_len_d = last_len_q;
        first_d    = first_q;
        eof_d      = eof_q;
        trunc_d    = trunc_q;
        orphan_d   = orphan_q;
        rd_en_c    = 1'b0;
        wr_en_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.in_empty) begin
                    rd_en_c = 1'b1;
                    if (bus.in_sof) begin
                        word_d           = '0;
                        word_d[WW-1 -: 8] = bus.in_dout;
                        keep_d           = keep_mask(IDX_W'(0));
                        idx_d            = IDX_W'(1);
                        len_d            = CNT_WIDTH'(1);
                        first_d          = 1'b1;
                        eof_d            = bus.in_eof;
                        trunc_d          = 1'b0;
                        orphan_d         = 1'b0;
                        state_d          = bus.in_eof ? ST_EMIT : ST_PACK;
                    end else begin
                        // Only the first byte of an orphan run is counted
                        if (!orphan_q && !(&err_q)) begin
                            err_d = err_q + CNT_WIDTH'(1);
                        end
                        orphan_d = 1'b1;
                    end
                end
            end

            ST_PACK: begin
                if (!bus.in_empty) begin
                    if (bus.in_sof) begin
                        // Next packet started early: close this one without popping
                        eof_d   = 1'b1;
                        trunc_d = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        rd_en_c = 1'b1;
                        for (int unsigned b = 0; b < OUT_BYTES; b++) begin
                            if (idx_q == IDX_W'(b)) begin
                                word_d[(OUT_BYTES-1-b)*8 +: 8] = bus.in_dout;
                            end
                        end
                        keep_d = keep_mask(idx_q);
                        idx_d  = idx_q + IDX_W'(1);
                        if (!(&len_q)) begin
                            len_d = len_q + CNT_WIDTH'(1);
                        end
                        eof_d = bus.in_eof;
                        if (bus.in_eof || (idx_q == IDX_W'(OUT_BYTES-1))) begin
                            state_d = ST_EMIT;
                        end
                    end
                end
            end

            ST_EMIT: begin
                if (!bus.out_full) begin
                    wr_en_c = 1'b1;
                    word_d  = '0;
                    keep_d  = '0;
                    idx_d   = '0;
                    first_d = 1'b0;
                    if (eof_q) begin
                        pkt_d      = pkt_q + CNT_WIDTH'(1);
                        last_len_d = len_q;
                        if (trunc_q && !(&err_q)) begin
                            err_d = err_q + CNT_WIDTH'(1);
                        end
                        eof_d   = 1'b0;
                        trunc_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PACK;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            keep_q     <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            pkt_q      <= '0;
            err_q      <= '0;
            last_len_q <= '0;
            first_q    <= 1'b0;
            eof_q      <= 1'b0;
            trunc_q    <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            keep_q     <= keep_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            pkt_q      <= pkt_d;
            err_q      <= err_d;
            last_len_q <= last_len_d;
            first_q    <= first_d;
            eof_q      <= eof_d;
            trunc_q    <= trunc_d;
            orphan_q   <= orphan_d;
        end
    end

    // FIFO strobes are suppressed while reset is held
    assign bus.in_rd_en  = rd_en_c & reset;
    assign bus.out_wr_en = wr_en_c & reset;
    assign bus.out_dout  = word_q;
    assign bus.out_keep  = keep_q;
    assign bus.out_sof   = first_q;
    assign bus.out_eof   = eof_q;

    assign pkt_count = pkt_q;
    assign err_count = err_q;
    assign last_len  = last_len_q;

endmodule

// File: tb/tb_udp_word_packer.sv
// Self-checking bench: FWFT byte source, word scoreboard, vector table plus corner sequences.
module tb_udp_word_packer;

    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } beat_t;

    typedef struct packed {
        logic [31:0] dout;
        logic [3:0]  keep;
        logic        sof;
        logic        eof;
    } word_t;

    typedef struct {
        int unsigned n_orphan;
        int unsigned trunc_len;
        logic [7:0]  seed;
        logic [7:0]  step;
        int unsigned len;
        int unsigned exp_words;
        int unsigned exp_pkts;
        int unsigned exp_errs;
        int unsigned exp_last_len;
        bit          gaps;
        bit          rfull;
    } vec_t;

    logic clock;
    logic reset;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] err_count;
    logic [CW-1:0] last_len;

    udp_word_packer_if bus_if();

    udp_word_packer #(
        .OUT_BYTES(4),
        .CNT_WIDTH(CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_if),
        .pkt_count (pkt_count),
        .err_count (err_count),
        .last_len  (last_len)
    );

    beat_t in_q[$];
    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    wr_cnt = 0;
    bit    pop_pending = 0;
    bit    gap_en = 0;
    bit    rand_full = 0;
    bit    full_req = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source model, sink model and scoreboard: inputs change on the falling edge
    initial begin
        word_t e;
        bus_if.in_dout  = '0;
        bus_if.in_sof   = 1'b0;
        bus_if.in_eof   = 1'b0;
        bus_if.in_empty = 1'b1;
        bus_if.out_full = 1'b0;
        forever begin
            @(negedge clock);
            if (pop_pending && in_q.size() > 0) void'(in_q.pop_front());
            pop_pending = 1'b0;
            if (in_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                bus_if.in_dout  = in_q[0].data;
                bus_if.in_sof   = in_q[0].sof;
                bus_if.in_eof   = in_q[0].eof;
                bus_if.in_empty = 1'b0;
            end else begin
                bus_if.in_dout  = '0;
                bus_if.in_sof   = 1'b0;
                bus_if.in_eof   = 1'b0;
                bus_if.in_empty = 1'b1;
            end
            bus_if.out_full = full_req || (rand_full && $urandom_range(0, 3) == 0);
            #1;
            if (bus_if.in_rd_en) begin
                check("rd_en_while_empty", 64'(bus_if.in_empty), 64'd0);
                pop_pending = !bus_if.in_empty;
            end
            if (bus_if.out_wr_en) begin
                check("wr_en_while_full", 64'(bus_if.out_full), 64'd0);
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected none",
                             {bus_if.out_dout, bus_if.out_keep, bus_if.out_sof, bus_if.out_eof});
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'({bus_if.out_dout, bus_if.out_keep, bus_if.out_sof, bus_if.out_eof}),
                          64'(e));
                end
            end
        end
    end

    // Queue a packet's bytes and the words it should produce
    task automatic push_pkt(input logic [7:0] seed, input logic [7:0] step, input int unsigned n, input bit trunc);
        logic [7:0] bytes [16];
        word_t w;
        int unsigned nw;
        nw = (n + 3) / 4;
        for (int unsigned i = 0; i < n; i++) begin
            bytes[i] = seed + 8'(i) * step;
            in_q.push_back('{data: bytes[i], sof: (i == 0), eof: ((i == n - 1) && !trunc)});
        end
        for (int unsigned c = 0; c < nw; c++) begin
            w = '0;
            w.sof = (c == 0);
            w.eof = (c == nw - 1);
            for (int unsigned k = 0; k < 4; k++) begin
                if (c * 4 + k < n) begin
                    w.dout[31 - 8*k -: 8] = bytes[c*4 + k];
                    w.keep[3 - k] = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
    endtask

    // Wait for all queued bytes and expected words to be consumed, then let counters settle
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
            @(negedge clock);
            #2;
            n++;
        end
        if (in_q.size() != 0 || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout_%s: got %0d bytes %0d words pending expected 0", name, in_q.size(), exp_q.size());
            in_q.delete();
            exp_q.delete();
        end
        repeat (2) @(negedge clock);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int unsigned exp_pkt;
        int unsigned exp_err;
        int base;
        int n;

        vecs[0] = '{0, 0, 8'h01, 8'h01, 8, 2, 1, 0, 8, 1'b0, 1'b0};
        vecs[1] = '{0, 0, 8'hAA, 8'h11, 5, 2, 1, 0, 5, 1'b0, 1'b0};
        vecs[2] = '{0, 0, 8'h5A, 8'h00, 1, 1, 1, 0, 1, 1'b0, 1'b0};
        vecs[3] = '{2, 0, 8'h30, 8'h01, 3, 1, 1, 1, 3, 1'b0, 1'b0};
        vecs[4] = '{0, 2, 8'h40, 8'h01, 6, 3, 2, 1, 6, 1'b0, 1'b0};
        vecs[5] = '{0, 0, 8'hC0, 8'h01, 4, 1, 1, 0, 4, 1'b1, 1'b1};
        vecs[6] = '{1, 3, 8'h80, 8'h03, 9, 4, 2, 2, 9, 1'b1, 1'b1};
        vecs[7] = '{0, 0, 8'hF0, 8'h01, 7, 2, 1, 0, 7, 1'b1, 1'b1};

        exp_pkt = 0;
        exp_err = 0;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        check("reset_strobes", 64'({bus_if.out_wr_en, bus_if.in_rd_en}), 64'd0);
        check("reset_word", 64'({bus_if.out_dout, bus_if.out_keep, bus_if.out_sof, bus_if.out_eof}), 64'd0);
        check("reset_counters", 64'({pkt_count, err_count, last_len}), 64'd0);
        reset = 1'b1;

        for (int v = 0; v < 8; v++) begin
            gap_en    = vecs[v].gaps;
            rand_full = vecs[v].rfull;
            base      = wr_cnt;
            for (int unsigned k = 0; k < vecs[v].n_orphan; k++) begin
                in_q.push_back('{data: 8'h11 * 8'(k + 1), sof: 1'b0, eof: 1'b0});
            end
            if (vecs[v].trunc_len != 0) push_pkt(8'hE0, 8'h01, vecs[v].trunc_len, 1'b1);
            push_pkt(vecs[v].seed, vecs[v].step, vecs[v].len, 1'b0);
            exp_pkt += vecs[v].exp_pkts;
            exp_err += vecs[v].exp_errs;
            drain($sformatf("vec%0d", v));
            gap_en    = 1'b0;
            rand_full = 1'b0;
            check($sformatf("vec%0d_words", v), 64'(wr_cnt - base), 64'(vecs[v].exp_words));
            check($sformatf("vec%0d_pkt_count", v), 64'(pkt_count), 64'(CW'(exp_pkt)));
            check($sformatf("vec%0d_err_count", v), 64'(err_count), 64'(CW'(exp_err)));
            check($sformatf("vec%0d_last_len", v), 64'(last_len), 64'(vecs[v].exp_last_len));
        end

        // Downstream full while a word is waiting
        full_req = 1'b1;
        base = wr_cnt;
        push_pkt(8'h61, 8'h01, 6, 1'b0);
        exp_pkt += 1;
        n = 0;
        do begin
            @(negedge clock);
            #2;
            n++;
        end while (in_q.size() != 2 && n < 50);
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL full_reach_emit: got %0d bytes left expected 2", in_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("full_hold_%0d", i),
                  64'({bus_if.out_wr_en, bus_if.in_rd_en, bus_if.out_dout, bus_if.out_keep, bus_if.out_sof, bus_if.out_eof}),
                  64'({1'b0, 1'b0, 32'h61626364, 4'hF, 1'b1, 1'b0}));
            @(negedge clock);
            #2;
        end
        check("full_no_write", 64'(wr_cnt - base), 64'd0);
        full_req = 1'b0;
        @(negedge clock);
        #2;
        check("write_on_release", 64'(wr_cnt - base), 64'd1);
        drain("full");
        check("full_pkt_count", 64'(pkt_count), 64'(CW'(exp_pkt)));
        check("full_last_len", 64'(last_len), 64'd6);

        // Reset in the middle of an open packet
        in_q.push_back('{data: 8'h71, sof: 1'b1, eof: 1'b0});
        in_q.push_back('{data: 8'h72, sof: 1'b0, eof: 1'b0});
        in_q.push_back('{data: 8'h73, sof: 1'b0, eof: 1'b0});
        drain("partial");
        check("partial_word", 64'({bus_if.out_dout, bus_if.out_keep}), 64'({32'h71727300, 4'hE}));
        reset = 1'b0;
        @(negedge clock);
        #2;
        check("midreset_word", 64'({bus_if.out_dout, bus_if.out_keep, bus_if.out_sof, bus_if.out_eof}), 64'd0);
        check("midreset_strobes", 64'({bus_if.out_wr_en, bus_if.in_rd_en}), 64'd0);
        check("midreset_counters", 64'({pkt_count, err_count, last_len}), 64'd0);
        reset = 1'b1;
        push_pkt(8'h90, 8'h01, 5, 1'b0);
        drain("after_reset");
        check("after_reset_pkt_count", 64'(pkt_count), 64'd1);
        check("after_reset_err_count", 64'(err_count), 64'd0);
        check("after_reset_last_len", 64'(last_len), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
